id_stage_pipe: RTL
==================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter INST_WIDTH, default 32: instruction width in bits.
REQ-002 Parameter INST_ADDR_WIDTH, default 32: PC width in bits.
REQ-003 Parameter DATA_WIDTH, default 32: immediate/datapath width in bits; SHALL be 32 or more.
REQ-004 Parameter STALL_CNT_WIDTH, default 16: width of the load-use stall counter.
REQ-005 Parameter HAZARD_EN, default 1: 1 enables load-use interlock; 0 disables it (hazard is never raised).
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 valid_in  in  1  IF/ID holds a valid instruction.
REQ-009 ready_out  out  1  stage accepts the IF/ID instruction this cycle.
REQ-010 inst_in  in  INST_WIDTH  instruction word.
REQ-011 pc_in, pc_plus_4_in  in  INST_ADDR_WIDTH each  PC and PC+4 of the instruction.
REQ-012 flush  in  1  EX redirect (taken branch/jump); kills ID contents.
REQ-013 ready_in  in  1  EX stage accepts the ID/EX register contents.
REQ-014 valid_out  out  1  ID/EX register holds a valid instruction.
REQ-015 pc_ex, pc_plus_4_ex  out  INST_ADDR_WIDTH  registered PC, PC+4.
REQ-016 rs1_ex, rs2_ex, rd_ex  out  5 each  registered register indices.
REQ-017 imm_ex  out  DATA_WIDTH  registered sign-extended immediate.
REQ-018 reg_write_ex, mem_write_ex, uncond_jump_ex, branch_ex, pc_jal_sel_ex  out  1 each  registered controls.
REQ-019 result_sel_ex  out  2  00 ALU, 01 memory, 10 PC+4.
REQ-020 alu_sel_0_ex, alu_sel_1_ex  out  2 each  ALU operand selects; alu_ctrl_ex  out  4  ALU operation.
REQ-021 illegal_ex  out  1  registered unrecognised-opcode flag.
REQ-022 stall_count  out  STALL_CNT_WIDTH  load-use stall cycles counted.

Function
REQ-023 Decode SHALL be combinational on inst_in for opcodes R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC; immediate per RV32I I/S/B/U/J format, sign-extended to DATA_WIDTH.
REQ-024 Any other opcode SHALL set illegal with all write-type controls (reg_write, mem_write, uncond_jump, branch) forced to 0.
REQ-025 alu_ctrl SHALL be {funct7[5],funct3} for R-type, {funct7[5],funct3} for I-ALU shifts with funct3=101, {0,funct3} for other I-ALU, 0000 (add) otherwise.
REQ-026 advance = !valid_out || ready_in.
REQ-027 hazard = HAZARD_EN && valid_in && valid_out && result_sel_ex==01 && rd_ex!=0 && (rd_ex==rs1 when rs1 used || rd_ex==rs2 when rs2 used); R/STORE/BRANCH use rs1,rs2; I-ALU/LOAD/JALR use rs1 only.
REQ-028 ready_out = flush || (advance && !hazard).
REQ-029 On flush: next-cycle valid_out=0 regardless of ready_in; incoming instruction discarded; stall_count unchanged; flush has priority over hazard and handshake.
REQ-030 Else if advance && hazard: ID/EX loads a bubble (valid_out=0, all controls 0); IF/ID not consumed; stall_count increments.
REQ-031 Else if advance: ID/EX loads decoded fields, valid_out=valid_in.
REQ-032 Else (!advance): ID/EX holds all outputs unchanged.
REQ-033 Latency SHALL be one cycle from accepted valid_in to valid_out.
REQ-034 A bubble (valid_out=0) SHALL force reg_write_ex and mem_write_ex to 0.
REQ-035 stall_count SHALL saturate at all-ones, never wrap.
REQ-036 Data fields (pc, imm, indices) of a bubble are don't-care; controls are not.

Reset
REQ-037 While rst=1, valid_out and every ID/EX output SHALL be 0 and stall_count SHALL be 0, asynchronously.
REQ-038 Reset mid-stall SHALL drop the held instruction; first cycle after release valid_out=0.

Verification
REQ-039 inst_in=0x00500093 (addi x1,x0,5), valid_in=1, ready_in=1 -> next cycle valid_out=1, rd_ex=1, imm_ex=5, reg_write_ex=1, result_sel_ex=00.
REQ-040 lw x5,0(x2) then add x6,x5,x7 back-to-back -> one cycle ready_out=0, bubble valid_out=0, then add issued; stall_count=1.
REQ-041 Same pair with rd=x0 load, or HAZARD_EN=0 -> no stall, stall_count=0.
REQ-042 ready_in=0 with valid_out=1 for 3 cycles -> all outputs stable, ready_out=0; flush asserted during that -> next cycle valid_out=0.
REQ-043 inst_in=0xFFFFFFFF -> illegal_ex=1, reg_write_ex=0, mem_write_ex=0.
REQ-044 STALL_CNT_WIDTH=2, five load-use stalls -> stall_count=3; rst pulse -> 0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I decode feeding an ID/EX register with load-use interlock and saturating stall counter
module id_stage_pipe #(
  parameter int INST_WIDTH = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STALL_CNT_WIDTH = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic [INST_WIDTH-1:0]      inst_in,
  input  logic [INST_ADDR_WIDTH-1:0] pc_in,
  input  logic [INST_ADDR_WIDTH-1:0] pc_plus_4_in,
  input  logic                       flush,
  input  logic                       ready_in,
  output logic                       valid_out,
  output logic [INST_ADDR_WIDTH-1:0] pc_ex,
  output logic [INST_ADDR_WIDTH-1:0] pc_plus_4_ex,
  output logic [4:0]                 rs1_ex,
  output logic [4:0]                 rs2_ex,
  output logic [4:0]                 rd_ex,
  output logic [DATA_WIDTH-1:0]      imm_ex,
  output logic                       reg_write_ex,
  output logic                       mem_write_ex,
  output logic                       uncond_jump_ex,
  output logic                       branch_ex,
  output logic                       pc_jal_sel_ex,
  output logic [1:0]                 result_sel_ex,
  output logic [1:0]                 alu_sel_0_ex,
  output logic [1:0]                 alu_sel_1_ex,
  output logic [3:0]                 alu_ctrl_ex,
  output logic                       illegal_ex,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);
  typedef struct packed {
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic [INST_ADDR_WIDTH-1:0] pc_plus_4;
    logic [4:0]                 rs1;
    logic [4:0]                 rs2;
    logic [4:0]                 rd;
    logic [DATA_WIDTH-1:0]      imm;
    logic                       reg_write;
    logic                       mem_write;
    logic                       uncond_jump;
    logic                       branch;
    logic                       pc_jal_sel;
    logic [1:0]                 result_sel;
    logic [1:0]                 alu_sel_0;
    logic [1:0]                 alu_sel_1;
    logic [3:0]                 alu_ctrl;
    logic                       illegal;
  } ex_t;
  ex_t dec, ex_q;
  logic [31:0] inst, imm32;
  logic [6:0] op;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
  logic use_rs2, use_rs1, advance, hazard, load, dep;
  assign inst = inst_in[31:0];
  assign op = inst[6:0];
  assign is_r = op == 7'b0110011;
  assign is_i = op == 7'b0010011;
  assign is_ld = op == 7'b0000011;
  assign is_st = op == 7'b0100011;
  assign is_br = op == 7'b1100011;
  assign is_jal = op == 7'b1101111;
  assign is_jalr = op == 7'b1100111;
  assign is_lui = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign legal = is_r || is_i || is_ld || is_st || is_br || is_jal || is_jalr || is_lui || is_auipc;
  assign use_rs2 = is_r || is_st || is_br;
  assign use_rs1 = use_rs2 || is_i || is_ld || is_jalr;
  assign imm32 = (is_i || is_ld || is_jalr) ? {{20{inst[31]}}, inst[31:20]} :
                 is_st ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                 is_br ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                 (is_lui || is_auipc) ? {inst[31:12], 12'b0} :
                 is_jal ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : 32'b0;
  always_comb begin
    dec = '0;
    dec.pc = pc_in;
    dec.pc_plus_4 = pc_plus_4_in;
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    dec.rd = inst[11:7];
    dec.imm = DATA_WIDTH'($signed(imm32));
    dec.reg_write = legal && !is_st && !is_br;
    dec.mem_write = is_st;
    dec.uncond_jump = is_jal || is_jalr;
    dec.branch = is_br;
    dec.pc_jal_sel = is_jalr;
    dec.result_sel = is_ld ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
    dec.alu_sel_0 = is_lui ? 2'b10 : (is_auipc || is_jal) ? 2'b01 : 2'b00;
    dec.alu_sel_1 = {1'b0, legal && !is_r && !is_br};
    dec.alu_ctrl = (is_r || (is_i && inst[14:12] == 3'b101)) ? {inst[30], inst[14:12]} :
                   is_i ? {1'b0, inst[14:12]} : 4'b0000;
    dec.illegal = !legal;
  end
  assign advance = !valid_out || ready_in;
  assign dep = (use_rs1 && ex_q.rd == inst[19:15]) || (use_rs2 && ex_q.rd == inst[24:20]);
  assign hazard = HAZARD_EN != 0 && valid_in && valid_out && ex_q.result_sel == 2'b01 && ex_q.rd != 5'd0 && dep;
  assign ready_out = flush || (advance && !hazard);
  assign load = !flush && advance && !hazard && valid_in;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
      valid_out <= 1'b0;
      stall_count <= '0;
    end else if (flush || advance) begin
      ex_q <= load ? dec : '0;
      valid_out <= load;
      if (!flush && hazard && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
  assign pc_ex = ex_q.pc;
  assign pc_plus_4_ex = ex_q.pc_plus_4;
  assign rs1_ex = ex_q.rs1;
  assign rs2_ex = ex_q.rs2;
  assign rd_ex = ex_q.rd;
  assign imm_ex = ex_q.imm;
  assign reg_write_ex = ex_q.reg_write;
  assign mem_write_ex = ex_q.mem_write;
  assign uncond_jump_ex = ex_q.uncond_jump;
  assign branch_ex = ex_q.branch;
  assign pc_jal_sel_ex = ex_q.pc_jal_sel;
  assign result_sel_ex = ex_q.result_sel;
  assign alu_sel_0_ex = ex_q.alu_sel_0;
  assign alu_sel_1_ex = ex_q.alu_sel_1;
  assign alu_ctrl_ex = ex_q.alu_ctrl;
  assign illegal_ex = ex_q.illegal;
endmodule
